// File: rtl/ps2_direction_rx.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver. It decodes the extended arrow-key make codes
// (E0 75/72/6B/74) into one-cycle up/down/left/right pulses for the snake game.
module ps2_direction_rx #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_error,
  output logic       up_P,
  output logic       down_P,
  output logic       left_P,
  output logic       right_P
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state_q;
  logic            clk_s1_q, clk_s2_q, clk_s3_q;
  logic            dat_s1_q, dat_s2_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic            par_ok_q;
  logic [WD_W-1:0] wd_q;
  logic            ext_q, brk_q;
  logic            fall_edge;
  logic            timeout;

  // Two-flop synchronizers; clk_s3_q keeps one cycle of clock history for edge detection.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall_edge = clk_s3_q & ~clk_s2_q;
  assign timeout   = (state_q != IDLE) && !fall_edge && (wd_q >= WD_LAST);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_ok_q    <= 1'b0;
      wd_q        <= '0;
      scan_code   <= 8'h00;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (state_q == IDLE || fall_edge) begin
        wd_q <= '0;
      end else if (wd_q != WD_MAX) begin
        wd_q <= wd_q + WD_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (fall_edge && !dat_s2_q) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        DATA: begin
          if (fall_edge) begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall_edge) begin
            par_ok_q <= ^{shift_q, dat_s2_q};
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (fall_edge) begin
            state_q <= IDLE;
            if (par_ok_q && dat_s2_q) begin
              scan_code  <= shift_q;
              code_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A stalled keyboard abandons the partial byte.
      if (timeout) begin
        state_q     <= IDLE;
        shift_q     <= 8'h00;
        bit_cnt_q   <= 3'd0;
        frame_error <= 1'b1;
      end
    end
  end

  // Prefix tracking: E0 marks extended keys, F0 marks a release; any other byte ends the key.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      up_P    <= 1'b0;
      down_P  <= 1'b0;
      left_P  <= 1'b0;
      right_P <= 1'b0;
    end else begin
      up_P    <= 1'b0;
      down_P  <= 1'b0;
      left_P  <= 1'b0;
      right_P <= 1'b0;
      if (frame_error) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (code_valid) begin
        case (scan_code)
          8'hE0: ext_q <= 1'b1;
          8'hF0: brk_q <= 1'b1;
          default: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (ext_q && !brk_q) begin
              case (scan_code)
                8'h75:   up_P    <= 1'b1;
                8'h72:   down_P  <= 1'b1;
                8'h6B:   left_P  <= 1'b1;
                8'h74:   right_P <= 1'b1;
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_rx.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for ps2_direction_rx: a frame driver feeds
// expectations from a key-sequence model, and a monitor pops them on every output pulse.
module tb_ps2_direction_rx;
  localparam int TO   = 400;
  localparam int HALF = 20;
  localparam int GAP  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, frame_error, up_P, down_P, left_P, right_P;

  ps2_direction_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clock_25(clk), .reset(rst_n), .ps2_clk(ps2c), .ps2_data(ps2d),
    .scan_code(scan_code), .code_valid(code_valid), .frame_error(frame_error),
    .up_P(up_P), .down_P(down_P), .left_P(left_P), .right_P(right_P)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = code_valid, 1 = frame_error, 2 = direction pulse
  typedef struct {
    int         kind;
    logic [7:0] code;
    int         dir;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         m_ext = 0, m_brk = 0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] dir_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int dir_of(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (dir_codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good, input int at);
    if (good) begin
      sbq.push_back('{0, b, -1, at});
      m_last = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (m_ext && !m_brk && dir_of(b) >= 0)
          sbq.push_back('{2, b, dir_of(b), (at < 0) ? -1 : at + 1});
        m_ext = 0;
        m_brk = 0;
      end
    end else begin
      sbq.push_back('{1, m_last, -1, at});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop, 3 stall after 4 data bits, 4 reset in 5th data bit
  task automatic send_frame(input logic [7:0] b, input int mode);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b);
    if (mode == 1) par = ~par;
    bits = {(mode == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (mode == 3 && i == 5) begin
        ps2d = 1'b1;
        model_frame(b, 1'b0, -1);
        tick(TO + 50);
        return;
      end
      ps2d = bits[i];
      tick(HALF);
      ps2c = 1'b0;
      if (i == 10) model_frame(b, mode == 0, cyc + 3);
      if (mode == 4 && i == 5) begin
        tick(5);
        rst_n = 1'b0;
        #1;
        check("rst_scan_code", scan_code, 0);
        check("rst_pulses", {code_valid, frame_error, up_P, down_P, left_P, right_P}, 0);
        ps2c = 1'b1;
        ps2d = 1'b1;
        m_ext = 0; m_brk = 0; m_last = 8'h00;
        tick(5);
        rst_n = 1'b1;
        tick(GAP);
        return;
      end
      tick(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(GAP);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  bit prev_cv = 0;
  always @(negedge clk) begin
    logic [3:0] dv;
    exp_t       e;
    int         act_kind;
    dv = {up_P, down_P, left_P, right_P};
    if (rst_n && (code_valid || frame_error || dv != 4'b0)) begin
      check("cv_fe_exclusive", int'(code_valid && frame_error), 0);
      check("dir_onehot", int'($countones(dv) > 1), 0);
      act_kind = code_valid ? 0 : (frame_error ? 1 : 2);
      if (sbq.size() == 0) begin
        check("unexpected_pulse_kind", act_kind, -1);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", act_kind, e.kind);
        if (e.at >= 0) check("pulse_cycle", cyc, e.at);
        case (e.kind)
          0: check("scan_code", scan_code, e.code);
          1: check("scan_code_kept", scan_code, e.code);
          default: begin
            check("dir_select", dv, 4'b1000 >> e.dir);
            check("dir_after_cv", int'(prev_cv), 1);
          end
        endcase
      end
    end
    prev_cv <= code_valid;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    int r;
    logic [7:0] rb;
    tick(5);
    check("reset_scan_code", scan_code, 0);
    check("reset_pulses", {code_valid, frame_error, up_P, down_P, left_P, right_P}, 0);
    rst_n = 1'b1;
    tick(10);

    send_frame(8'h1C, 0);
    for (int i = 0; i < 4; i++) begin
      send_frame(8'hE0, 0);
      send_frame(dir_codes[i], 0);
    end
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    send_frame(8'h75, 0);
    send_frame(8'h75, 1);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hA5, 3);
    send_frame(8'h74, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hE0, 4);
    send_frame(8'hE0, 0); send_frame(8'h74, 0);
    send_frame(8'hE0, 0); send_frame(8'h72, 2); send_frame(8'h72, 0);

    for (int k = 0; k < 30; k++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      case (r)
        0, 1, 2: send_frame(rb, 0);
        3, 4, 5: begin
          send_frame(8'hE0, 0);
          send_frame(dir_codes[$urandom_range(0, 3)], 0);
        end
        6: begin
          send_frame(8'hE0, 0);
          send_frame(8'hF0, 0);
          send_frame(dir_codes[$urandom_range(0, 3)], 0);
        end
        7: send_frame(dir_codes[$urandom_range(0, 3)], 0);
        8: send_frame(rb, 1);
        default: send_frame(rb, 2);
      endcase
    end

    for (int w = 0; w < 100 && sbq.size() != 0; w++) tick(1);
    check("scoreboard_drained", sbq.size(), 0);
    check("final_scan_code", scan_code, m_last);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_direction_rx.md
PS2_DIRECTION_RX -- requirements
Module: ps2_direction_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25000, meaning the frame watchdog limit in clock_25 cycles (1 ms at 25 MHz).
REQ-002 SHALL have port clock_25  input  1  single system clock; all logic is in this domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous, idles high.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous, idles high.
REQ-006 SHALL have port scan_code  output  8  last correctly received byte.
REQ-007 SHALL have port code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.
REQ-009 SHALL have ports up_P, down_P, left_P, right_P  output  1 each  one-cycle direction pulses that feed the snake FSM alongside KEY2/KEY3.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers, and detect a falling edge when the synchronized ps2_clk history is 1 then 0.
REQ-011 SHALL sample synchronized ps2_data only on a detected falling edge.
REQ-012 SHALL implement frame states IDLE, DATA, PARITY, STOP.
REQ-013 In IDLE, SHALL move to DATA on an edge with data=0 (start bit); an edge with data=1 SHALL be ignored and the state SHALL remain IDLE.
REQ-014 In DATA, SHALL shift in 8 bits LSB-first using a 3-bit counter, then move to PARITY.
REQ-015 In PARITY, SHALL capture the parity bit; the frame passes when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-016 In STOP, on an edge, SHALL return to IDLE.
  - Parity OK and stop bit=1: load scan_code, pulse code_valid.
  - Otherwise: pulse frame_error; scan_code unchanged.
REQ-017 SHALL assert code_valid in the 3rd clock_25 cycle after the stop-bit falling edge arrives at the ps2_clk pin (2 synchronizer cycles + 1 register cycle).
REQ-018 SHALL count cycles since the last edge while outside IDLE.
  - Count reaching TIMEOUT_CYCLES: return to IDLE, pulse frame_error, discard the partial byte.
  - Counter SHALL clear on every edge and while in IDLE, and SHALL saturate (no wrap-around).
REQ-019 SHALL decode received bytes into two sticky flags, ext and brk.
  - 0xE0 sets ext; 0xF0 sets brk.
  - Any other byte completes a key and clears both flags in the same cycle.
REQ-020 On a completed key with ext=1 and brk=0, SHALL pulse exactly one direction output one cycle after code_valid: 0x75 gives up_P, 0x72 down_P, 0x6B left_P, 0x74 right_P.
REQ-021 SHALL ignore non-extended 0x75/0x72/0x6B/0x74 (keypad keys), any break sequence, and all other codes; no pulse is produced.
REQ-022 SHALL produce one pulse per typematic repeat (each repeated E0 xx make sequence).
REQ-023 A frame_error SHALL clear ext and brk.
REQ-024 At most one of code_valid/frame_error, and at most one direction pulse, SHALL be asserted in any cycle.
REQ-025 This block SHALL never drive ps2_clk or ps2_data (receive-only; no host-to-device commands).

Reset
REQ-026 While reset=0: frame state IDLE; scan_code=0x00; code_valid, frame_error, all direction outputs, ext, brk, bit counter, watchdog counter and synchronizer flops all 0, except the synchronizer flops, which SHALL reset to 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; after release, reception SHALL resume at the next start bit.

Verification
REQ-028 Send frame 0x1C with parity 0 (10 kHz PS/2 clock) -> scan_code=0x1C, one code_valid pulse, no direction pulse.
REQ-029 Send E0, 75 -> two code_valid pulses; exactly one up_P pulse, one cycle after the second code_valid; repeat with 72/6B/74 -> down_P/left_P/right_P respectively.
REQ-030 Send E0, F0, 6B -> three code_valid pulses, no direction pulse, ext=brk=0 afterwards.
REQ-031 Send 0x75 with a wrong parity bit -> one frame_error pulse, scan_code keeps its prior value, no up_P; a following E0, 75 -> up_P.
REQ-032 Stop ps2_clk after 4 data bits for more than 25000 cycles -> frame_error pulse, state IDLE; the next full frame 0x74 is received correctly.
REQ-033 Assert reset during the 5th data bit of E0 -> all outputs 0 immediately; after release, E0, 74 -> right_P.
